// File: rtl/hazard_scoreboard_if.sv
// Decode-side connection of the hazard scoreboard: the decoded
// instruction description going in, and the stall/flush/forward
// controls plus HI/LO busy and stall statistic coming back.
interface hazard_scoreboard_if #(
    parameter int NSRC   = 2,
    parameter int AW     = 5,
    parameter int TW     = 3,
    parameter int NSTAGE = 3,
    parameter int CW     = 16
);
    localparam int SW = $clog2(NSTAGE + 1);

    logic                 d_valid;
    logic [NSRC*AW-1:0]   d_src;
    logic [NSRC*TW-1:0]   d_tuse;
    logic                 d_wr;
    logic [AW-1:0]        d_dst;
    logic [TW-1:0]        d_tnew;
    logic [1:0]           d_md_start;
    logic                 d_md_use;
    logic                 stat_clr;

    logic                 stall_o;
    logic                 pc_en_o;
    logic                 d_en_o;
    logic                 e_flush_o;
    logic [NSRC*SW-1:0]   fwd_d_o;
    logic [NSRC*SW-1:0]   fwd_e_o;
    logic                 md_busy_o;
    logic [CW-1:0]        stall_cnt_o;

    // decode stage drives the instruction, receives the controls
    modport master (
        output d_valid, d_src, d_tuse, d_wr, d_dst, d_tnew,
               d_md_start, d_md_use, stat_clr,
        input  stall_o, pc_en_o, d_en_o, e_flush_o, fwd_d_o, fwd_e_o,
               md_busy_o, stall_cnt_o
    );

    // hazard unit consumes the instruction, produces the controls
    modport slave (
        input  d_valid, d_src, d_tuse, d_wr, d_dst, d_tnew,
               d_md_start, d_md_use, stat_clr,
        output stall_o, pc_en_o, d_en_o, e_flush_o, fwd_d_o, fwd_e_o,
               md_busy_o, stall_cnt_o
    );
endinterface

// File: rtl/hazard_scoreboard.sv
// Hazard-control unit beside the decode stage. It tracks in-flight
// register writes (dst, Tnew) for every post-decode stage itself and
// derives D stall / E flush and D/E forward selects from them. It also
// owns the HI/LO busy counter and a saturating stall-cycle counter.
// NSTAGE must be at least 2 (E plus at least one forwarding stage).
module hazard_scoreboard #(
    parameter int NSRC    = 2,
    parameter int AW      = 5,
    parameter int TW      = 3,
    parameter int NSTAGE  = 3,
    parameter int MUL_LAT = 5,
    parameter int DIV_LAT = 10,
    parameter int CW      = 16
) (
    input logic           clk,
    input logic           reset,
    hazard_scoreboard_if.slave bus
);
    localparam int SW     = $clog2(NSTAGE + 1);
    localparam int MD_MAX = (DIV_LAT > MUL_LAT) ? DIV_LAT : MUL_LAT;
    localparam int MW     = $clog2(MD_MAX + 1);

    // Scoreboard entry k describes the instruction now in stage k.
    logic [NSTAGE:1]              ent_valid_r;
    logic [NSTAGE:1]              ent_wr_r;
    logic [NSTAGE:1][AW-1:0]      ent_dst_r;
    logic [NSTAGE:1][TW-1:0]      ent_tnew_r;
    logic [NSRC*AW-1:0]           e_src_r;
    logic [MW-1:0]                md_cnt_r;
    logic [CW-1:0]                stall_cnt_r;

    logic                         data_stall_s;
    logic                         md_stall_s;
    logic                         stall_s;
    logic                         advance_s;
    logic [NSRC*SW-1:0]           fwd_d_s;
    logic [NSRC*SW-1:0]           fwd_e_s;

    // A stage produces the operand when it holds a real, writing
    // instruction whose non-zero destination equals the source.
    function automatic logic is_producer(
        input logic          valid,
        input logic          wr,
        input logic [AW-1:0] dst,
        input logic [AW-1:0] src
    );
        return valid & wr & (dst != {AW{1'b0}}) & (dst == src);
    endfunction

    // Tnew counts down one per stage and sticks at zero.
    function automatic logic [TW-1:0] tnew_step(input logic [TW-1:0] tnew);
        return (tnew == {TW{1'b0}}) ? {TW{1'b0}} : tnew - {{(TW-1){1'b0}}, 1'b1};
    endfunction

    // Data hazards and forward selects; stages scanned oldest to youngest
    // so the youngest producer's decision is the one left standing.
    always_comb begin
        data_stall_s = 1'b0;
        fwd_d_s      = '0;
        fwd_e_s      = '0;
        for (int i = 0; i < NSRC; i++) begin
            for (int k = NSTAGE; k >= 1; k--) begin
                if (is_producer(ent_valid_r[k], ent_wr_r[k], ent_dst_r[k],
                                bus.d_src[i*AW +: AW])) begin
                    data_stall_s = data_stall_s |
                                   (bus.d_tuse[i*TW +: TW] < ent_tnew_r[k]);
                    fwd_d_s[i*SW +: SW] = (ent_tnew_r[k] == {TW{1'b0}}) ?
                                          SW'(k) : {SW{1'b0}};
                end else begin
                    fwd_d_s[i*SW +: SW] = fwd_d_s[i*SW +: SW];
                end
            end
            for (int k = NSTAGE; k >= 2; k--) begin
                if (is_producer(ent_valid_r[k], ent_wr_r[k], ent_dst_r[k],
                                e_src_r[i*AW +: AW])) begin
                    fwd_e_s[i*SW +: SW] = (ent_tnew_r[k] == {TW{1'b0}}) ?
                                          SW'(k) : {SW{1'b0}};
                end else begin
                    fwd_e_s[i*SW +: SW] = fwd_e_s[i*SW +: SW];
                end
            end
        end
    end

    assign md_stall_s = bus.d_md_use & (md_cnt_r != {MW{1'b0}});
    assign stall_s    = bus.d_valid & (data_stall_s | md_stall_s);
    assign advance_s  = bus.d_valid & ~stall_s;

    assign bus.stall_o     = stall_s;
    assign bus.pc_en_o     = ~stall_s;
    assign bus.d_en_o      = ~stall_s;
    assign bus.e_flush_o   = stall_s;
    assign bus.fwd_d_o     = fwd_d_s;
    assign bus.fwd_e_o     = fwd_e_s;
    assign bus.md_busy_o   = (md_cnt_r != {MW{1'b0}});
    assign bus.stall_cnt_o = stall_cnt_r;

    // Advance the scoreboard: D enters E (or a bubble does), the rest shift.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ent_valid_r <= '0;
            ent_wr_r    <= '0;
            ent_dst_r   <= '0;
            ent_tnew_r  <= '0;
            e_src_r     <= '0;
        end else begin
            ent_valid_r[1] <= advance_s;
            ent_wr_r[1]    <= advance_s & bus.d_wr;
            ent_dst_r[1]   <= advance_s ? bus.d_dst  : {AW{1'b0}};
            ent_tnew_r[1]  <= advance_s ? bus.d_tnew : {TW{1'b0}};
            e_src_r        <= advance_s ? bus.d_src  : {(NSRC*AW){1'b0}};
            for (int k = 2; k <= NSTAGE; k++) begin
                ent_valid_r[k] <= ent_valid_r[k-1];
                ent_wr_r[k]    <= ent_wr_r[k-1];
                ent_dst_r[k]   <= ent_dst_r[k-1];
                ent_tnew_r[k]  <= tnew_step(ent_tnew_r[k-1]);
            end
        end
    end

    // HI/LO busy counter: (re)loaded by a start entering E, else counts down.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            md_cnt_r <= {MW{1'b0}};
        end else if (advance_s & bus.d_md_start[1]) begin
            md_cnt_r <= MW'(DIV_LAT);
        end else if (advance_s & bus.d_md_start[0]) begin
            md_cnt_r <= MW'(MUL_LAT);
        end else if (md_cnt_r != {MW{1'b0}}) begin
            md_cnt_r <= md_cnt_r - {{(MW-1){1'b0}}, 1'b1};
        end else begin
            md_cnt_r <= md_cnt_r;
        end
    end

    // Saturating stall-cycle statistic; a clear beats an increment.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt_r <= {CW{1'b0}};
        end else if (bus.stat_clr) begin
            stall_cnt_r <= {CW{1'b0}};
        end else if (stall_s & (stall_cnt_r != {CW{1'b1}})) begin
            stall_cnt_r <= stall_cnt_r + {{(CW-1){1'b0}}, 1'b1};
        end else begin
            stall_cnt_r <= stall_cnt_r;
        end
    end
endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: each driven cycle pushes its
// expected outputs to a queue that is popped and compared mid-cycle.
module tb_hazard_scoreboard;
    logic clk;
    logic reset;
    int   n_cmp;
    int   n_err;

    typedef struct {
        logic        stall;
        logic        busy;
        logic [3:0]  fd;
        logic [3:0]  fe;
        logic [15:0] cnt;
    } exp_t;

    exp_t  exp_q[$];
    string tag_q[$];
    exp_t  cur_e;
    string cur_tag;

    hazard_scoreboard_if bus ();

    hazard_scoreboard dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic idle();
        bus.d_valid    = 1'b0;
        bus.d_src      = 10'd0;
        bus.d_tuse     = 6'd0;
        bus.d_wr       = 1'b0;
        bus.d_dst      = 5'd0;
        bus.d_tnew     = 3'd0;
        bus.d_md_start = 2'b00;
        bus.d_md_use   = 1'b0;
        bus.stat_clr   = 1'b0;
    endtask

    // One D-stage cycle: apply inputs after the edge, queue what must be seen.
    task automatic drive(input string tag, input logic v, input logic wr,
                         input logic [4:0] dst, input logic [2:0] tnew,
                         input logic [9:0] src, input logic [5:0] tuse,
                         input logic [1:0] mds, input logic mdu, input logic clr,
                         input logic e_stall, input logic e_busy,
                         input logic [3:0] e_fd, input logic [3:0] e_fe,
                         input logic [15:0] e_cnt);
        exp_t e;
        @(posedge clk);
        #1;
        bus.d_valid    = v;
        bus.d_wr       = wr;
        bus.d_dst      = dst;
        bus.d_tnew     = tnew;
        bus.d_src      = src;
        bus.d_tuse     = tuse;
        bus.d_md_start = mds;
        bus.d_md_use   = mdu;
        bus.stat_clr   = clr;
        e.stall = e_stall;
        e.busy  = e_busy;
        e.fd    = e_fd;
        e.fe    = e_fe;
        e.cnt   = e_cnt;
        exp_q.push_back(e);
        tag_q.push_back(tag);
    endtask

    task automatic drain(input int n, input logic [15:0] e_cnt);
        for (int j = 0; j < n; j++)
            drive("drain", 1'b0, 1'b0, 5'd0, 3'd0, 10'd0, 6'd0, 2'b00, 1'b0, 1'b0,
                  1'b0, 1'b0, 4'd0, 4'd0, e_cnt);
    endtask

    // Compare the oldest queued expectation against the DUT mid-cycle.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            cur_e   = exp_q.pop_front();
            cur_tag = tag_q.pop_front();
            check_val({cur_tag, ".stall"},   32'(bus.stall_o),     32'(cur_e.stall));
            check_val({cur_tag, ".pc_en"},   32'(bus.pc_en_o),     32'(!cur_e.stall));
            check_val({cur_tag, ".d_en"},    32'(bus.d_en_o),      32'(!cur_e.stall));
            check_val({cur_tag, ".e_flush"}, 32'(bus.e_flush_o),   32'(cur_e.stall));
            check_val({cur_tag, ".fwd_d"},   32'(bus.fwd_d_o),     32'(cur_e.fd));
            check_val({cur_tag, ".fwd_e"},   32'(bus.fwd_e_o),     32'(cur_e.fe));
            check_val({cur_tag, ".md_busy"}, 32'(bus.md_busy_o),   32'(cur_e.busy));
            check_val({cur_tag, ".cnt"},     32'(bus.stall_cnt_o), 32'(cur_e.cnt));
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_cmp = 0;
        n_err = 0;
        reset = 1'b0;
        idle();

        // Held in reset: even a stall-looking request yields reset values.
        drive("in_reset", 1'b1, 1'b1, 5'd9, 3'd2, {5'd0, 5'd9}, 6'd0, 2'b10, 1'b1, 1'b0,
              1'b0, 1'b0, 4'd0, 4'd0, 16'd0);
        @(negedge clk);
        #1;
        idle();
        reset = 1'b1;

        // Load-use: lw r8 (Tnew 2) then addu reading r8 with Tuse 1.
        drive("lu_lw",    1'b1, 1'b1, 5'd8, 3'd2, 10'd0, 6'd0, 2'b00, 1'b0, 1'b0,
              1'b0, 1'b0, 4'd0, 4'd0, 16'd0);
        drive("lu_stall", 1'b1, 1'b1, 5'd9, 3'd1, {5'd0, 5'd8}, {3'd7, 3'd1}, 2'b00, 1'b0, 1'b0,
              1'b1, 1'b0, 4'd0, 4'd0, 16'd0);
        drive("lu_rel",   1'b1, 1'b1, 5'd9, 3'd1, {5'd0, 5'd8}, {3'd7, 3'd1}, 2'b00, 1'b0, 1'b0,
              1'b0, 1'b0, 4'd0, 4'd0, 16'd1);
        drive("lu_e_fwd", 1'b0, 1'b0, 5'd0, 3'd0, 10'd0, 6'd0, 2'b00, 1'b0, 1'b0,
              1'b0, 1'b0, 4'd0, 4'b0011, 16'd1);
        drain(3, 16'd1);

        // Branch: addu r4 (Tnew 1) then beq reading r4 with Tuse 0.
        drive("br_addu",  1'b1, 1'b1, 5'd4, 3'd1, 10'd0, 6'd0, 2'b00, 1'b0, 1'b0,
              1'b0, 1'b0, 4'd0, 4'd0, 16'd1);
        drive("br_stall", 1'b1, 1'b0, 5'd0, 3'd0, {5'd0, 5'd4}, {3'd7, 3'd0}, 2'b00, 1'b0, 1'b0,
              1'b1, 1'b0, 4'd0, 4'd0, 16'd1);
        drive("br_rel",   1'b1, 1'b0, 5'd0, 3'd0, {5'd0, 5'd4}, {3'd7, 3'd0}, 2'b00, 1'b0, 1'b0,
              1'b0, 1'b0, 4'b0010, 4'd0, 16'd2);
        drive("br_e_fwd", 1'b0, 1'b0, 5'd0, 3'd0, 10'd0, 6'd0, 2'b00, 1'b0, 1'b0,
              1'b0, 1'b0, 4'd0, 4'b0011, 16'd2);
        drain(3, 16'd2);

        // Priority: r5 in M and in W (both Tnew 0); operand 1 must take M.
        drive("pr_w",     1'b1, 1'b1, 5'd5, 3'd0, 10'd0, 6'd0, 2'b00, 1'b0, 1'b0,
              1'b0, 1'b0, 4'd0, 4'd0, 16'd2);
        drive("pr_m",     1'b1, 1'b1, 5'd5, 3'd0, 10'd0, 6'd0, 2'b00, 1'b0, 1'b0,
              1'b0, 1'b0, 4'd0, 4'd0, 16'd2);
        drain(1, 16'd2);
        drive("pr_use",   1'b1, 1'b0, 5'd0, 3'd0, {5'd5, 5'd0}, 6'd0, 2'b00, 1'b0, 1'b0,
              1'b0, 1'b0, 4'b1000, 4'd0, 16'd2);
        drive("pr_e_fwd", 1'b0, 1'b0, 5'd0, 3'd0, 10'd0, 6'd0, 2'b00, 1'b0, 1'b0,
              1'b0, 1'b0, 4'd0, 4'b1100, 16'd2);
        drain(3, 16'd2);

        // Zero register is never a hazard nor a forward source.
        drive("z_prod",   1'b1, 1'b1, 5'd0, 3'd2, 10'd0, 6'd0, 2'b00, 1'b0, 1'b0,
              1'b0, 1'b0, 4'd0, 4'd0, 16'd2);
        drive("z_use",    1'b1, 1'b0, 5'd0, 3'd0, 10'd0, 6'd0, 2'b00, 1'b0, 1'b0,
              1'b0, 1'b0, 4'd0, 4'd0, 16'd2);
        drain(3, 16'd2);

        // mult then mflo: five stall cycles, statistic ends at 5.
        drive("clr1", 1'b0, 1'b0, 5'd0, 3'd0, 10'd0, 6'd0, 2'b00, 1'b0, 1'b1,
              1'b0, 1'b0, 4'd0, 4'd0, 16'd2);
        drive("mul_issue", 1'b1, 1'b0, 5'd0, 3'd0, 10'd0, 6'd0, 2'b01, 1'b0, 1'b0,
              1'b0, 1'b0, 4'd0, 4'd0, 16'd0);
        for (int i = 0; i < 5; i++)
            drive("mul_wait", 1'b1, 1'b1, 5'd2, 3'd1, 10'd0, 6'd0, 2'b00, 1'b1, 1'b0,
                  1'b1, 1'b1, 4'd0, 4'd0, 16'(i));
        drive("mul_rel", 1'b1, 1'b1, 5'd2, 3'd1, 10'd0, 6'd0, 2'b00, 1'b1, 1'b0,
              1'b0, 1'b0, 4'd0, 4'd0, 16'd5);
        drain(3, 16'd5);

        // div (both start bits set, div wins) then mflo: ten stall cycles.
        drive("clr2", 1'b0, 1'b0, 5'd0, 3'd0, 10'd0, 6'd0, 2'b00, 1'b0, 1'b1,
              1'b0, 1'b0, 4'd0, 4'd0, 16'd5);
        drive("div_issue", 1'b1, 1'b0, 5'd0, 3'd0, 10'd0, 6'd0, 2'b11, 1'b0, 1'b0,
              1'b0, 1'b0, 4'd0, 4'd0, 16'd0);
        for (int i = 0; i < 10; i++)
            drive("div_wait", 1'b1, 1'b1, 5'd2, 3'd1, 10'd0, 6'd0, 2'b00, 1'b1, 1'b0,
                  1'b1, 1'b1, 4'd0, 4'd0, 16'(i));
        drive("div_rel", 1'b1, 1'b1, 5'd2, 3'd1, 10'd0, 6'd0, 2'b00, 1'b1, 1'b0,
              1'b0, 1'b0, 4'd0, 4'd0, 16'd10);
        drain(3, 16'd10);

        // Reset in the middle of a div wait.
        drive("clr3", 1'b0, 1'b0, 5'd0, 3'd0, 10'd0, 6'd0, 2'b00, 1'b0, 1'b1,
              1'b0, 1'b0, 4'd0, 4'd0, 16'd10);
        drive("rd_issue", 1'b1, 1'b0, 5'd0, 3'd0, 10'd0, 6'd0, 2'b10, 1'b0, 1'b0,
              1'b0, 1'b0, 4'd0, 4'd0, 16'd0);
        for (int i = 0; i < 3; i++)
            drive("rd_wait", 1'b1, 1'b1, 5'd2, 3'd1, 10'd0, 6'd0, 2'b00, 1'b1, 1'b0,
                  1'b1, 1'b1, 4'd0, 4'd0, 16'(i));
        @(posedge clk);
        #1;
        check_val("pre_rst.stall", 32'(bus.stall_o), 32'd1);
        check_val("pre_rst.cnt", 32'(bus.stall_cnt_o), 32'd3);
        #1;
        reset = 1'b0;
        #1;
        check_val("async_rst.stall",   32'(bus.stall_o),     32'd0);
        check_val("async_rst.pc_en",   32'(bus.pc_en_o),     32'd1);
        check_val("async_rst.d_en",    32'(bus.d_en_o),      32'd1);
        check_val("async_rst.e_flush", 32'(bus.e_flush_o),   32'd0);
        check_val("async_rst.md_busy", 32'(bus.md_busy_o),   32'd0);
        check_val("async_rst.cnt",     32'(bus.stall_cnt_o), 32'd0);
        check_val("async_rst.fwd_d",   32'(bus.fwd_d_o),     32'd0);
        check_val("async_rst.fwd_e",   32'(bus.fwd_e_o),     32'd0);
        @(negedge clk);
        #1;
        idle();
        reset = 1'b1;
        drive("post_rst_mflo", 1'b1, 1'b1, 5'd2, 3'd1, 10'd0, 6'd0, 2'b00, 1'b1, 1'b0,
              1'b0, 1'b0, 4'd0, 4'd0, 16'd0);
        drive("post_rst_idle", 1'b0, 1'b0, 5'd0, 3'd0, 10'd0, 6'd0, 2'b00, 1'b0, 1'b0,
              1'b0, 1'b0, 4'd0, 4'd0, 16'd0);

        for (int i = 0; i < 5 && exp_q.size() > 0; i++)
            @(negedge clk);
        #1;
        check_val("queue_drain", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
